// File: rtl/byte_to_word.sv
// Assembles four UART RX bytes (MSB first) into a 32-bit word and hands it to the
// consumer through a one-word valid/ack holding register with timeout and overrun.
module byte_to_word #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    input  logic        word_taken,
    input  logic        clear_err,
    output logic        word_ready,
    output logic [31:0] data_out,
    output logic        receiving_word,
    output logic        overrun,
    output logic        timeout_tick
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state, state_next;
    logic [1:0]       count, count_next;
    logic [31:0]      shift_buf, shift_next;
    logic [CNT_W-1:0] idle_cnt, idle_next;
    logic [31:0]      word_new;
    logic             word_done;
    logic             expire;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        count_next = count;
        shift_next = shift_buf;
        idle_next  = '0;
        word_new   = {shift_buf[23:0], rx_data};
        word_done  = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done_tick) begin
                    shift_next = word_new;
                    count_next = 2'd1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_done_tick) begin
                    shift_next = word_new;
                    if (count == 2'd3) begin
                        word_done  = 1'b1;
                        count_next = 2'd0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + 2'd1;
                    end
                end else if (TIMEOUT_EN && idle_cnt == LAST_CNT) begin
                    // A byte on the expiry cycle is handled above, so it always wins.
                    expire     = 1'b1;
                    count_next = 2'd0;
                    shift_next = '0;
                    state_next = IDLE;
                end else if (TIMEOUT_EN) begin
                    idle_next = idle_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 2'd0;
            shift_buf <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            shift_buf <= shift_next;
            idle_cnt  <= idle_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_ready   <= 1'b0;
            data_out     <= '0;
            overrun      <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            timeout_tick <= expire;
            if (word_done && (!word_ready || word_taken)) begin
                data_out   <= word_new;
                word_ready <= 1'b1;
            end else if (!word_done && word_taken) begin
                word_ready <= 1'b0;
            end
            // A new overrun takes priority over a simultaneous clear.
            if (word_done && word_ready && !word_taken) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign receiving_word = (state == COLLECT);

endmodule
